// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter
// Three-master to one-slave Avalon-MM arbiter for the main-memory port.
// Master 0 = debug host, 1 = dbus, 2 = ibus. A grant is held for one whole
// Avalon transfer, from the command until the slave drops waitrequest.
// The slave-side command is a pure mux of the registered one-hot grant.
//
// Build option:
//   ARBITER_RR_EN  defined   -> round-robin arbitration with a pointer register
//                  undefined -> fixed priority 0 > 1 > 2, no pointer
// Under both policies the master that just finished is skipped when the
// next winner is picked in its completion cycle.

module avalon_mm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // master 0: debug host
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byte_enable,
    input  logic [DW-1:0]     m0_writedata,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_waitrequest,

    // master 1: core data bus
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byte_enable,
    input  logic [DW-1:0]     m1_writedata,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_waitrequest,

    // master 2: core instruction bus
    input  logic              m2_read,
    input  logic              m2_write,
    input  logic [AW-1:0]     m2_address,
    input  logic [DW/8-1:0]   m2_byte_enable,
    input  logic [DW-1:0]     m2_writedata,
    output logic [DW-1:0]     m2_readdata,
    output logic              m2_waitrequest,

    // slave port
    output logic              s_read,
    output logic              s_write,
    output logic [AW-1:0]     s_address,
    output logic [DW/8-1:0]   s_byte_enable,
    output logic [DW-1:0]     s_writedata,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_waitrequest,

    // debug view of the current owner
    output logic [2:0]        grant
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q;
    logic [2:0] grant_q;

    logic [2:0] req;          // per-master request, bit i = master i
    logic       owner_req;    // granted master still holds its command
    logic [2:0] cand;         // masters eligible in this arbitration cycle
    logic [2:0] winner;       // one-hot arbitration result, 0 if nobody eligible

    assign req       = {m2_read | m2_write, m1_read | m1_write, m0_read | m0_write};
    assign owner_req = |(req & grant_q);

    // Lowest index wins; also used on the rotated vector for round-robin.
    function automatic logic [2:0] pick_fixed(input logic [2:0] c);
        if (c[0])      pick_fixed = 3'b001;
        else if (c[1]) pick_fixed = 3'b010;
        else if (c[2]) pick_fixed = 3'b100;
        else           pick_fixed = 3'b000;
    endfunction

`ifdef ARBITER_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Rotate so the pointer master sits at bit 0, pick lowest, rotate back.
    function automatic logic [2:0] pick_rr(input logic [2:0] c, input logic [1:0] p);
        logic [2:0] rot;
        logic [2:0] sel;
        case (p)
            2'd1:    rot = {c[0], c[2], c[1]};
            2'd2:    rot = {c[1], c[0], c[2]};
            default: rot = c;
        endcase
        sel = pick_fixed(rot);
        case (p)
            2'd1:    pick_rr = {sel[1], sel[0], sel[2]};
            2'd2:    pick_rr = {sel[0], sel[2], sel[1]};
            default: pick_rr = sel;
        endcase
    endfunction
`endif

    // Arbitration: all requesters from IDLE, everyone but the owner on handover.
    always_comb begin
        // NOTE: every always_comb output gets a value before any branch; a path
        // that leaves one unassigned turns it into a latch.
        cand = (state_q == BUSY) ? (req & ~grant_q) : req;
`ifdef ARBITER_RR_EN
        winner = pick_rr(cand, ptr_q);
`else
        winner = pick_fixed(cand);
`endif
    end

`ifdef ARBITER_RR_EN
    // Next pointer is the master after the winner, modulo three.
    always_comb begin
        ptr_d = ptr_q;
        case (winner)
            3'b001:  ptr_d = 2'd1;
            3'b010:  ptr_d = 2'd2;
            3'b100:  ptr_d = 2'd0;
            default: ptr_d = ptr_q;
        endcase
    end
`endif

    // Grant FSM: latch a winner, hold it for the transfer, hand over or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
`ifdef ARBITER_RR_EN
            ptr_q   <= 2'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|winner) begin
                        state_q <= BUSY;
                        grant_q <= winner;
`ifdef ARBITER_RR_EN
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        // owner abandoned its command: give the port up
                        state_q <= IDLE;
                        grant_q <= 3'b000;
                    end else if (!s_waitrequest) begin
                        if (|winner) begin
                            // zero-latency handover to another requester
                            grant_q <= winner;
`ifdef ARBITER_RR_EN
                            ptr_q   <= ptr_d;
`endif
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 3'b000;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 3'b000;
                end
            endcase
        end
    end

    // Slave command: AND-OR mux of the granted master, all zero when idle.
    always_comb begin
        s_read        = |(grant_q & {m2_read, m1_read, m0_read});
        s_write       = |(grant_q & {m2_write, m1_write, m0_write});
        s_address     = ({AW{grant_q[0]}} & m0_address)
                      | ({AW{grant_q[1]}} & m1_address)
                      | ({AW{grant_q[2]}} & m2_address);
        s_byte_enable = ({(DW/8){grant_q[0]}} & m0_byte_enable)
                      | ({(DW/8){grant_q[1]}} & m1_byte_enable)
                      | ({(DW/8){grant_q[2]}} & m2_byte_enable);
        s_writedata   = ({DW{grant_q[0]}} & m0_writedata)
                      | ({DW{grant_q[1]}} & m1_writedata)
                      | ({DW{grant_q[2]}} & m2_writedata);
    end

    // Response routing: only the owner sees the slave, the others are stalled.
    always_comb begin
        m0_waitrequest = grant_q[0] ? s_waitrequest : 1'b1;
        m1_waitrequest = grant_q[1] ? s_waitrequest : 1'b1;
        m2_waitrequest = grant_q[2] ? s_waitrequest : 1'b1;
        m0_readdata    = grant_q[0] ? s_readdata : '0;
        m1_readdata    = grant_q[1] ? s_readdata : '0;
        m2_readdata    = grant_q[2] ? s_readdata : '0;
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Testbench for avalon_mm_arbiter: reset, table-driven contention vectors,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level model. Works with or without ARBITER_RR_EN.
`timescale 1ns/1ps

module tb_avalon_mm_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mrd[3];
    logic          mwr[3];
    logic [AW-1:0] maddr[3];
    logic [BW-1:0] mbe[3];
    logic [DW-1:0] mwd[3];
    logic [DW-1:0] mrdata[3];
    logic          mwait[3];
    logic          s_read, s_write;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_byte_enable;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata;
    logic          s_waitrequest;
    logic [2:0]    grant;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state: owning master (-1 = idle) and round-robin pointer
    int owner;
    int ptr;

    always #5 clk = ~clk;

    avalon_mm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_read(mrd[0]), .m0_write(mwr[0]), .m0_address(maddr[0]),
        .m0_byte_enable(mbe[0]), .m0_writedata(mwd[0]),
        .m0_readdata(mrdata[0]), .m0_waitrequest(mwait[0]),
        .m1_read(mrd[1]), .m1_write(mwr[1]), .m1_address(maddr[1]),
        .m1_byte_enable(mbe[1]), .m1_writedata(mwd[1]),
        .m1_readdata(mrdata[1]), .m1_waitrequest(mwait[1]),
        .m2_read(mrd[2]), .m2_write(mwr[2]), .m2_address(maddr[2]),
        .m2_byte_enable(mbe[2]), .m2_writedata(mwd[2]),
        .m2_readdata(mrdata[2]), .m2_waitrequest(mwait[2]),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_byte_enable(s_byte_enable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant)
    );

    typedef struct {
        logic [2:0] rd;          // read requests {m2,m1,m0}
        logic       swait;       // slave waitrequest
        logic [2:0] exp_grant;
        logic       exp_sread;
        logic [2:0] exp_mwait;   // {m2,m1,m0}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        for (int i = 0; i < 3; i++) begin
            mrd[i] = 1'b0; mwr[i] = 1'b0; maddr[i] = '0; mbe[i] = '0; mwd[i] = '0;
        end
    endtask

    task automatic pulse_reset();
        idle_masters();
        s_waitrequest = 1'b0;
        s_readdata    = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        owner = -1;
        ptr   = 0;
        next_cycle();
    endtask

    // first eligible master in priority order (fixed 0,1,2 or from pointer)
    function automatic int pick(input logic [2:0] cand, input int p);
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = RR ? (p + k) % 3 : k;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    // model transition at a rising edge, from the inputs present at that edge
    task automatic model_edge(input logic [2:0] req, input logic swait);
        int w;
        logic [2:0] c;
        if (owner < 0) begin
            w = pick(req, ptr);
            if (w >= 0) begin
                owner = w;
                ptr   = (w + 1) % 3;
            end
        end else if (!req[owner]) begin
            owner = -1;
        end else if (!swait) begin
            c = req;
            c[owner] = 1'b0;
            w = pick(c, ptr);
            owner = w;
            if (w >= 0) ptr = (w + 1) % 3;
        end
    endtask

    function automatic logic [2:0] cur_req();
        return {mrd[2] | mwr[2], mrd[1] | mwr[1], mrd[0] | mwr[0]};
    endfunction

    initial begin
        int completions;
        logic [2:0]    eg;
        logic [AW-1:0] ea;
        logic          ewait[3];

        // ---------------- stimulus table ----------------
        // single m2 read, then all three masters contending, then all drop
        vecs[0] = '{3'b100, 1'b0, 3'b000, 1'b0, 3'b111};
        vecs[1] = '{3'b100, 1'b0, 3'b100, 1'b1, 3'b011};
        vecs[2] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b111};
        vecs[3] = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b111};
        vecs[4] = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b110};
        vecs[5] = '{3'b111, 1'b0, 3'b010, 1'b1, 3'b101};
        if (RR) begin
            vecs[6] = '{3'b111, 1'b0, 3'b100, 1'b1, 3'b011};
            vecs[7] = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b110};
            vecs[8] = '{3'b111, 1'b0, 3'b010, 1'b1, 3'b101};
            vecs[9] = '{3'b000, 1'b0, 3'b100, 1'b0, 3'b011};
        end else begin
            vecs[6] = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b110};
            vecs[7] = '{3'b111, 1'b0, 3'b010, 1'b1, 3'b101};
            vecs[8] = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b110};
            vecs[9] = '{3'b000, 1'b0, 3'b010, 1'b0, 3'b101};
        end
        vecs[10] = '{3'b000, 1'b0, 3'b000, 1'b0, 3'b111};

        // ---------------- reset with everybody requesting ----------------
        idle_masters();
        rst_n = 1'b0;
        s_waitrequest = 1'b0;
        s_readdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) mrd[i] = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_grant", grant, 3'b000);
        check("rst_s_read", s_read, 1'b0);
        check("rst_s_write", s_write, 1'b0);
        check("rst_mwait", {mwait[2], mwait[1], mwait[0]}, 3'b111);
        check("rst_mrdata", {mrdata[2], mrdata[1], mrdata[0]}, 96'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_grant_early", grant, 3'b000);
        next_cycle();
        @(negedge clk);
        check("rel_grant", grant, 3'b001);
        next_cycle();

        // ---------------- table-driven vectors ----------------
        pulse_reset();
        maddr[0] = 32'h40; maddr[1] = 32'h80; maddr[2] = 32'h100;
        s_readdata = 32'hDEAD_BEEF;
        for (int r = 0; r < 11; r++) begin
            for (int i = 0; i < 3; i++) mrd[i] = vecs[r].rd[i];
            s_waitrequest = vecs[r].swait;
            @(negedge clk);
            ea = '0;
            for (int i = 0; i < 3; i++) if (vecs[r].exp_grant[i]) ea = maddr[i];
            check($sformatf("tbl%0d_grant", r), grant, vecs[r].exp_grant);
            check($sformatf("tbl%0d_s_read", r), s_read, vecs[r].exp_sread);
            check($sformatf("tbl%0d_s_write", r), s_write, 1'b0);
            check($sformatf("tbl%0d_s_address", r), s_address, ea);
            check($sformatf("tbl%0d_mwait", r), {mwait[2], mwait[1], mwait[0]}, vecs[r].exp_mwait);
            for (int i = 0; i < 3; i++)
                check($sformatf("tbl%0d_m%0d_rdata", r, i), mrdata[i],
                      vecs[r].exp_grant[i] ? 32'hDEAD_BEEF : 32'h0);
            next_cycle();
        end

        // ---------------- stalled write with m0 waiting ----------------
        pulse_reset();
        mwr[1] = 1'b1; maddr[1] = 32'h200; mbe[1] = 4'b0011; mwd[1] = 32'hA5A5_A5A5;
        s_waitrequest = 1'b1;
        @(negedge clk);
        check("sw_idle_grant", grant, 3'b000);
        next_cycle();
        mrd[0] = 1'b1; maddr[0] = 32'h40;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) s_waitrequest = 1'b0;
            @(negedge clk);
            check($sformatf("sw%0d_grant", k), grant, 3'b010);
            check($sformatf("sw%0d_s_write", k), s_write, 1'b1);
            check($sformatf("sw%0d_s_read", k), s_read, 1'b0);
            check($sformatf("sw%0d_s_address", k), s_address, 32'h200);
            check($sformatf("sw%0d_s_be", k), s_byte_enable, 4'b0011);
            check($sformatf("sw%0d_s_wdata", k), s_writedata, 32'hA5A5_A5A5);
            check($sformatf("sw%0d_m0_wait", k), mwait[0], 1'b1);
            check($sformatf("sw%0d_m1_wait", k), mwait[1], (k == 3) ? 1'b0 : 1'b1);
            next_cycle();
        end
        mwr[1] = 1'b0;
        s_readdata = 32'h1234_5678;
        @(negedge clk);
        check("sw_handover_grant", grant, 3'b001);
        check("sw_handover_s_read", s_read, 1'b1);
        check("sw_handover_s_address", s_address, 32'h40);
        check("sw_handover_m0_wait", mwait[0], 1'b0);
        check("sw_handover_m0_rdata", mrdata[0], 32'h1234_5678);
        check("sw_handover_m1_wait", mwait[1], 1'b1);
        check("sw_handover_m1_rdata", mrdata[1], 32'h0);
        next_cycle();
        mrd[0] = 1'b0;
        @(negedge clk);
        check("sw_end_grant", grant, 3'b000);
        next_cycle();

        // ---------------- back-to-back reads from m2 alone ----------------
        pulse_reset();
        mrd[2] = 1'b1; maddr[2] = 32'h100;
        completions = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_grant", c), grant, (c % 2 == 1) ? 3'b100 : 3'b000);
            if (mwait[2] == 1'b0) completions++;
            next_cycle();
        end
        mrd[2] = 1'b0;
        check("b2b_completions", completions, 4);

        // ---------------- reset in the middle of a stalled write ----------------
        pulse_reset();
        mwr[1] = 1'b1; maddr[1] = 32'h300; mbe[1] = 4'hF; mwd[1] = 32'h0BAD_F00D;
        s_waitrequest = 1'b1;
        s_readdata = 32'hCAFE_0001;
        next_cycle();
        @(negedge clk);
        check("mr_pre_s_write", s_write, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_s_write", s_write, 1'b0);
        check("mr_m1_wait", mwait[1], 1'b1);
        check("mr_m1_rdata", mrdata[1], 32'h0);
        check("mr_grant", grant, 3'b000);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        s_waitrequest = 1'b0;
        @(negedge clk);
        check("mr_regrant", grant, 3'b010);
        check("mr_regrant_s_write", s_write, 1'b1);
        check("mr_regrant_m1_wait", mwait[1], 1'b0);
        next_cycle();
        mwr[1] = 1'b0;
        @(negedge clk);
        check("mr_end_grant", grant, 3'b000);
        next_cycle();

        // ---------------- randomized run against the model ----------------
        pulse_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(mrd[i] | mwr[i])) begin
                    if ($urandom_range(0, 99) < 40) begin
                        if ($urandom_range(0, 1) == 0) mrd[i] = 1'b1;
                        else                            mwr[i] = 1'b1;
                        maddr[i] = $urandom;
                        mbe[i]   = BW'($urandom);
                        mwd[i]   = $urandom;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    mrd[i] = 1'b0;
                    mwr[i] = 1'b0;
                end
            end
            s_waitrequest = ($urandom_range(0, 99) < 40);
            s_readdata    = $urandom;
            @(negedge clk);
            eg = '0;
            if (owner >= 0) eg[owner] = 1'b1;
            check("rnd_grant", grant, eg);
            check("rnd_s_read", s_read, (owner >= 0) ? mrd[owner] : 1'b0);
            check("rnd_s_write", s_write, (owner >= 0) ? mwr[owner] : 1'b0);
            check("rnd_s_address", s_address, (owner >= 0) ? maddr[owner] : '0);
            check("rnd_s_be", s_byte_enable, (owner >= 0) ? mbe[owner] : '0);
            check("rnd_s_wdata", s_writedata, (owner >= 0) ? mwd[owner] : '0);
            for (int i = 0; i < 3; i++) begin
                ewait[i] = (owner == i) ? s_waitrequest : 1'b1;
                check($sformatf("rnd_m%0d_wait", i), mwait[i], ewait[i]);
                check($sformatf("rnd_m%0d_rdata", i), mrdata[i], (owner == i) ? s_readdata : '0);
            end
            @(posedge clk);
            model_edge(cur_req(), s_waitrequest);
            #1;
            for (int i = 0; i < 3; i++) begin
                if ((mrd[i] | mwr[i]) && !ewait[i]) begin
                    mrd[i] = 1'b0;
                    mwr[i] = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
